nary_perceptron_trainer: RTL

Parametrised successor to the 2-input binary perceptron. It supports N binary inputs, a truth table of 2^N targets, and Q4.4-style signed weights of width W with saturating updates. An on-chip training FSM runs the perceptron learning rule over all 2^N samples per epoch, one sample per cycle. It sits behind the AXI-slave register wrapper alongside the existing perceptron IP.

---
 rtl/nary_perceptron_trainer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/nary_perceptron_trainer.sv
// N-input perceptron with an on-chip training FSM, saturating signed weights and registered prediction.
// Optional define PERCEPTRON_ERRCNT_EN adds err_count (misclassified samples in last completed epoch).
module nary_perceptron_trainer #(
  parameter int N = 2,
  parameter int W = 8,
  localparam int S = 1 << N,
  localparam int SW = W + $clog2(N + 1) + 1
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [N-1:0]      x,
  output logic              y,
  output logic [SW-1:0]     sum_dbg,
  input  logic              train_start,
  input  logic              train_abort,
  input  logic [S-1:0]      targets,
  input  logic [15:0]       max_epochs,
  input  logic [W-1:0]      eta,
  input  logic              load_init,
  input  logic [N*W-1:0]    w_init,
  input  logic [W-1:0]      b_init,
  output logic [N*W-1:0]    w_o,
  output logic [W-1:0]      b_o,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [15:0]       epoch_count
`ifdef PERCEPTRON_ERRCNT_EN
  ,
  output logic [N:0]        err_count
`endif
);

  // state | meaning
  // IDLE  | waiting for load_init / train_start
  // RUN   | presenting sample idx, applying the learning rule
  // CHECK | end of epoch: count it, decide converge / limit / next epoch
  // DONE  | one-cycle completion, returns to IDLE
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  localparam logic signed [W:0] SAT_HI = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] SAT_LO = {2'b11, {(W-1){1'b0}}};

  state_t            state_q, state_d;
  logic [N*W-1:0]    w_q;
  logic [W-1:0]      b_q;
  logic [N-1:0]      idx;
  logic              err_flag;
  logic signed [SW-1:0] sum_x, sum_t;
  logic              p_t, err_pos, err_neg;
  logic [16:0]       epoch_next;

  function automatic logic signed [SW-1:0] dot(input logic [N*W-1:0] wv,
                                                input logic [W-1:0] bv,
                                                input logic [N-1:0] sel);
    logic signed [SW-1:0] acc;
    acc = $signed({{(SW-W){bv[W-1]}}, bv});
    for (int i = 0; i < N; i++) begin
      if (sel[i]) acc = acc + $signed({{(SW-W){wv[i*W+W-1]}}, wv[i*W +: W]});
    end
    return acc;
  endfunction

  // One extra bit holds a +/- eta step exactly, so clamping is a plain compare.
  function automatic logic [W-1:0] sat_step(input logic [W-1:0] a,
                                            input logic [W-1:0] d,
                                            input logic neg);
    logic signed [W:0] s;
    if (neg) s = $signed({a[W-1], a}) - $signed({d[W-1], d});
    else     s = $signed({a[W-1], a}) + $signed({d[W-1], d});
    if (s > SAT_HI)      s = SAT_HI;
    else if (s < SAT_LO) s = SAT_LO;
    return s[W-1:0];
  endfunction

  always_comb begin
    sum_x   = dot(w_q, b_q, x);
    sum_t   = dot(w_q, b_q, idx);
    p_t     = !sum_t[SW-1] && (sum_t != '0);
    err_pos = targets[idx] && !p_t;
    err_neg = !targets[idx] && p_t;
  end

  assign epoch_next = {1'b0, epoch_count} + 17'd1;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (train_start) state_d = (max_epochs == 16'd0) ? DONE : RUN;
      end
      RUN: begin
        if (train_abort)     state_d = IDLE;
        else if (idx == '1)  state_d = CHECK;
      end
      CHECK: begin
        if (train_abort)                          state_d = IDLE;
        else if (!err_flag)                       state_d = DONE;
        else if (epoch_next >= {1'b0, max_epochs}) state_d = DONE;
        else                                      state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef PERCEPTRON_ERRCNT_EN
  logic [N:0] err_acc;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      w_q         <= '0;
      b_q         <= '0;
      y           <= 1'b0;
      sum_dbg     <= '0;
      done        <= 1'b0;
      converged   <= 1'b0;
      epoch_count <= '0;
      idx         <= '0;
      err_flag    <= 1'b0;
`ifdef PERCEPTRON_ERRCNT_EN
      err_acc     <= '0;
      err_count   <= '0;
`endif
    end else begin
      y       <= !sum_x[SW-1] && (sum_x != '0);
      sum_dbg <= sum_x;
      case (state_q)
        IDLE: begin
          if (load_init) begin
            w_q  <= w_init;
            b_q  <= b_init;
            done <= 1'b0;
          end
          if (train_start) begin
            done        <= 1'b0;
            converged   <= 1'b0;
            epoch_count <= '0;
            idx         <= '0;
            err_flag    <= 1'b0;
`ifdef PERCEPTRON_ERRCNT_EN
            err_acc     <= '0;
            err_count   <= '0;
`endif
          end
        end
        RUN: begin
          if (train_abort) begin
            done      <= 1'b1;
            converged <= 1'b0;
          end else begin
            if (err_pos || err_neg) begin
              for (int i = 0; i < N; i++) begin
                if (idx[i]) w_q[i*W +: W] <= sat_step(w_q[i*W +: W], eta, err_neg);
              end
              b_q      <= sat_step(b_q, eta, err_neg);
              err_flag <= 1'b1;
`ifdef PERCEPTRON_ERRCNT_EN
              err_acc  <= err_acc + 1'b1;
`endif
            end
            idx <= idx + 1'b1;
          end
        end
        CHECK: begin
          if (train_abort) begin
            done      <= 1'b1;
            converged <= 1'b0;
          end else begin
            epoch_count <= epoch_count + 16'd1;
            if (!err_flag) converged <= 1'b1;
            idx      <= '0;
            err_flag <= 1'b0;
`ifdef PERCEPTRON_ERRCNT_EN
            err_count <= err_acc;
            err_acc   <= '0;
`endif
          end
        end
        default: ;
      endcase
      if (state_d == DONE) done <= 1'b1;
    end
  end

  assign w_o  = w_q;
  assign b_o  = b_q;
  assign busy = (state_q == RUN) || (state_q == CHECK);

endmodule
